// File: rtl/regfile_wb_sched.sv
// Write-back arbiter (round-robin over ALU/load/muldiv) and per-register hazard scoreboard.
// Optional same-cycle forwarding from the write port when REGFILE_WB_BYPASS_EN is defined.
module regfile_wb_sched #(
   parameter int unsigned NSRC = 3,
   parameter int unsigned DW   = 16,
   parameter int unsigned AW   = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NSRC-1:0]      wb_valid,
   input  logic [NSRC*AW-1:0]   wb_addr,
   input  logic [NSRC*DW-1:0]   wb_data,
   output logic [NSRC-1:0]      wb_ready,
   output logic                 we3,
   output logic [AW-1:0]        wa3,
   output logic [DW-1:0]        wd3,
   input  logic                 iss_valid,
   input  logic [AW-1:0]        iss_dst,
   output logic                 iss_ready,
   input  logic [AW-1:0]        ra1,
   input  logic [AW-1:0]        ra2,
   input  logic                 use1,
   input  logic                 use2,
   output logic                 stall,
   output logic                 err_underflow
`ifdef REGFILE_WB_BYPASS_EN
   ,
   output logic                 fwd1,
   output logic                 fwd2,
   output logic [DW-1:0]        fwd_data
`endif
);

   localparam int unsigned NREG = 1 << AW;
   localparam int unsigned PW   = $clog2(NSRC);

   logic [PW-1:0] rr_q, rr_d;
   logic          we3_q;
   logic [AW-1:0] wa3_q;
   logic [DW-1:0] wd3_q;
   logic [1:0]    cnt_q [NREG];
   logic [1:0]    cnt_d [NREG];
   logic          err_q, err_d;

   logic            grant;
   logic [PW-1:0]   win;
   logic [AW-1:0]   win_addr;
   logic [DW-1:0]   win_data;
   logic [NREG-1:0] inc, dec;
   logic            hz1, hz2;

   // First valid requester at or after the pointer, wrapping.
   always_comb begin
      int unsigned idx;
      idx      = 0;
      wb_ready = '0;
      grant    = 1'b0;
      win      = rr_q;
      for (int unsigned k = 0; k < NSRC; k++) begin
         idx = (32'(rr_q) + k) % NSRC;
         if (!grant && wb_valid[idx]) begin
            grant         = 1'b1;
            win           = PW'(idx);
            wb_ready[idx] = 1'b1;
         end
      end
   end

   assign win_addr = wb_addr[32'(win) * AW +: AW];
   assign win_data = wb_data[32'(win) * DW +: DW];

   always_comb begin
      rr_d = rr_q;
      if (grant) begin
         rr_d = (win == PW'(NSRC - 1)) ? '0 : win + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q  <= '0;
         we3_q <= 1'b0;
         wa3_q <= '0;
         wd3_q <= '0;
      end else begin
         rr_q  <= rr_d;
         // Writes to r0 are consumed but never reach the register file.
         we3_q <= grant && (win_addr != '0);
         if (grant && (win_addr != '0)) begin
            wa3_q <= win_addr;
            wd3_q <= win_data;
         end
      end
   end

   assign we3 = we3_q;
   assign wa3 = wa3_q;
   assign wd3 = wd3_q;

   assign iss_ready = (iss_dst == '0) || (cnt_q[iss_dst] != 2'd3);

   always_comb begin
      inc = '0;
      dec = '0;
      if (iss_valid && iss_ready && (iss_dst != '0)) inc[iss_dst] = 1'b1;
      if (we3_q) dec[wa3_q] = 1'b1;
   end

   // A retire and an issue to the same register cancel out.
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      for (int r = 0; r < NREG; r++) begin
         if (r == 0) begin
            cnt_d[r] = '0;
         end else if (inc[r] && !dec[r]) begin
            if (cnt_q[r] != 2'd3) cnt_d[r] = cnt_q[r] + 2'd1;
         end else if (dec[r] && !inc[r]) begin
            if (cnt_q[r] == 2'd0) err_d = 1'b1;
            else                  cnt_d[r] = cnt_q[r] - 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err_underflow = err_q;

`ifdef REGFILE_WB_BYPASS_EN
   // Last outstanding write is on the port right now: decode can take wd3 directly.
   assign fwd1     = we3_q && (wa3_q == ra1) && (ra1 != '0) && (cnt_q[ra1] == 2'd1);
   assign fwd2     = we3_q && (wa3_q == ra2) && (ra2 != '0) && (cnt_q[ra2] == 2'd1);
   assign fwd_data = wd3_q;
   assign hz1 = (ra1 != '0) && (cnt_q[ra1] != 2'd0) && !fwd1;
   assign hz2 = (ra2 != '0) && (cnt_q[ra2] != 2'd0) && !fwd2;
`else
   assign hz1 = (ra1 != '0) && (cnt_q[ra1] != 2'd0);
   assign hz2 = (ra2 != '0) && (cnt_q[ra2] != 2'd0);
`endif

   assign stall = (use1 && hz1) || (use2 && hz2) || (iss_valid && !iss_ready);

endmodule
